// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Purpose  : Operand/op request and result response bundle for alu_mc.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] regA;
   logic [DATA_W-1:0] regB;
   logic [OP_W-1:0]   Operation;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] ALUResult;
   logic              zero;
   logic              illegal;

   modport master (
      output in_valid, regA, regB, Operation, out_ready,
      input  in_ready, out_valid, ALUResult, zero, illegal
   );

   modport slave (
      input  in_valid, regA, regB, Operation, out_ready,
      output in_ready, out_valid, ALUResult, zero, illegal
   );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with registered result and valid/ready on both
//            sides. Iterative MUL/MULHU/DIVU/REMU exist only when the macro
//            ALU_MC_MULDIV_EN is defined; otherwise those codes are illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   localparam logic [OP_W-1:0] c_op_and   = OP_W'(4'b0000);
   localparam logic [OP_W-1:0] c_op_or    = OP_W'(4'b0001);
   localparam logic [OP_W-1:0] c_op_add   = OP_W'(4'b0010);
   localparam logic [OP_W-1:0] c_op_xor   = OP_W'(4'b0011);
   localparam logic [OP_W-1:0] c_op_sll   = OP_W'(4'b0100);
   localparam logic [OP_W-1:0] c_op_srl   = OP_W'(4'b0101);
   localparam logic [OP_W-1:0] c_op_sub   = OP_W'(4'b0110);
   localparam logic [OP_W-1:0] c_op_sra   = OP_W'(4'b0111);
   localparam logic [OP_W-1:0] c_op_slt   = OP_W'(4'b1000);
   localparam logic [OP_W-1:0] c_op_sltu  = OP_W'(4'b1001);
`ifdef ALU_MC_MULDIV_EN
   localparam logic [OP_W-1:0] c_op_mul   = OP_W'(4'b1010);
   localparam logic [OP_W-1:0] c_op_mulhu = OP_W'(4'b1011);
   localparam logic [OP_W-1:0] c_op_divu  = OP_W'(4'b1100);
   localparam logic [OP_W-1:0] c_op_remu  = OP_W'(4'b1101);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_accept;
   logic              w_muldiv;
   logic [SH_W-1:0]   w_sh;
   logic [DATA_W-1:0] w_res;
   logic              w_ill;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic              r_illegal;

   assign w_sh     = bus.regB[SH_W-1:0];
   assign w_accept = bus.in_valid & w_in_ready;

   // Single-cycle datapath works straight off the bus so the result can be
   // latched on the accept edge itself.
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      case (bus.Operation)
         c_op_and:  w_res = bus.regA & bus.regB;
         c_op_or:   w_res = bus.regA | bus.regB;
         c_op_xor:  w_res = bus.regA ^ bus.regB;
         c_op_add:  w_res = bus.regA + bus.regB;
         c_op_sub:  w_res = bus.regA - bus.regB;
         c_op_sll:  w_res = bus.regA << w_sh;
         c_op_srl:  w_res = bus.regA >> w_sh;
         c_op_sra:  w_res = $unsigned($signed(bus.regA) >>> w_sh);
         c_op_slt:  w_res = {{(DATA_W-1){1'b0}}, ($signed(bus.regA) < $signed(bus.regB))};
         c_op_sltu: w_res = {{(DATA_W-1){1'b0}}, (bus.regA < bus.regB)};
         default: begin
            w_res = '0;
            w_ill = 1'b1;
         end
      endcase
   end

`ifdef ALU_MC_MULDIV_EN
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [SH_W-1:0]   r_count;
   logic              w_is_div;
   logic              w_r_div;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W-1:0] w_hi_n;
   logic [DATA_W-1:0] w_lo_n;
   logic [DATA_W-1:0] w_md_res;

   assign w_muldiv = (bus.Operation == c_op_mul)  | (bus.Operation == c_op_mulhu) |
                     (bus.Operation == c_op_divu) | (bus.Operation == c_op_remu);
   assign w_is_div = (bus.Operation == c_op_divu) | (bus.Operation == c_op_remu);
   assign w_r_div  = (r_op == c_op_divu) | (r_op == c_op_remu);

   // {r_hi,r_lo} is the product accumulator (multiplier shifted out of r_lo)
   // or the remainder/quotient pair. A zero divisor needs no special case:
   // every trial succeeds, giving all-ones quotient and remainder = dividend.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
      w_shift = {r_hi, r_lo[DATA_W-1]};
      w_trial = w_shift - {1'b0, r_b};
      w_hi_n  = w_sum[DATA_W:1];
      w_lo_n  = {w_sum[0], r_lo[DATA_W-1:1]};
      if (w_r_div) begin
         if (!w_trial[DATA_W]) begin
            w_hi_n = w_trial[DATA_W-1:0];
            w_lo_n = {r_lo[DATA_W-2:0], 1'b1};
         end else begin
            w_hi_n = w_shift[DATA_W-1:0];
            w_lo_n = {r_lo[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign w_md_res = ((r_op == c_op_mul) || (r_op == c_op_divu)) ? w_lo_n : w_hi_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_count <= '0;
      end else if (w_accept && w_muldiv) begin
         r_a     <= bus.regA;
         r_b     <= bus.regB;
         r_op    <= bus.Operation;
         r_hi    <= '0;
         r_lo    <= w_is_div ? bus.regA : bus.regB;
         r_count <= SH_W'(DATA_W - 1);
      end else if (r_state == BUSY) begin
         r_hi <= w_hi_n;
         r_lo <= w_lo_n;
         if (r_count != '0) begin
            r_count <= r_count - 1'b1;
         end
      end
   end
`else
   assign w_muldiv = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_next = w_muldiv ? BUSY : DONE;
            end
         end
         BUSY: begin
`ifdef ALU_MC_MULDIV_EN
            if (r_count == '0) begin
               w_state_next = DONE;
            end
`else
            w_state_next = IDLE;
`endif
         end
         DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               w_state_next = bus.in_valid ? (w_muldiv ? BUSY : DONE) : IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Result flags move only when a new result is latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept && !w_muldiv) begin
         r_result  <= w_res;
         r_zero    <= (w_res == '0);
         r_illegal <= w_ill;
      end
`ifdef ALU_MC_MULDIV_EN
      else if ((r_state == BUSY) && (r_count == '0)) begin
         r_result  <= w_md_res;
         r_zero    <= (w_md_res == '0);
         r_illegal <= 1'b0;
      end
`endif
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.ALUResult = r_result;
   assign bus.zero      = r_zero;
   assign bus.illegal   = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc against a bench-side model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
   localparam int DW = 32;
`ifdef ALU_MC_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   alu_mc_if #(.DATA_W(DW), .OP_W(4)) bus ();

   alu_mc #(.DATA_W(DW), .OP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
      int          due;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   bit   m_ev;

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t            e;
      longint unsigned p;
      int              sh;
      e.res = 32'h0;
      e.ill = 1'b0;
      e.lat = 1;
      e.due = 0;
      sh    = int'(b[4:0]);
      p     = {32'h0, a} * {32'h0, b};
      case (op)
         4'h0: e.res = a & b;
         4'h1: e.res = a | b;
         4'h3: e.res = a ^ b;
         4'h2: e.res = a + b;
         4'h6: e.res = a - b;
         4'h4: e.res = a << sh;
         4'h5: e.res = a >> sh;
         4'h7: e.res = $unsigned($signed(a) >>> sh);
         4'h8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h9: e.res = (a < b) ? 32'd1 : 32'd0;
         4'hA, 4'hB, 4'hC, 4'hD: begin
            if (MD) begin
               e.lat = DW + 1;
               case (op)
                  4'hA:    e.res = p[31:0];
                  4'hB:    e.res = p[63:32];
                  4'hC:    e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
                  default: e.res = (b == 0) ? a : a % b;
               endcase
            end else begin
               e.ill = 1'b1;
            end
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) e.res = 32'h0;
      e.z = (e.res == 32'h0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual 0x%08h required 0x%08h at t=%0t", name, act, req, $time);
      end
   endtask

   // Compare process: the queue head becomes due a fixed latency after accept.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
         check("rst_result", bus.ALUResult, 32'h0);
         q.delete();
      end else begin
         m_ev = (q.size() > 0) && (cyc >= q[0].due);
         check("mon_out_valid", {31'h0, bus.out_valid}, {31'h0, m_ev});
         if (m_ev) begin
            check("mon_result", bus.ALUResult, q[0].res);
            check("mon_zero", {31'h0, bus.zero}, {31'h0, q[0].z});
            check("mon_illegal", {31'h0, bus.illegal}, {31'h0, q[0].ill});
         end
         check("mon_in_ready", {31'h0, bus.in_ready},
               (q.size() == 0) ? 32'h1 : (m_ev ? {31'h0, bus.out_ready} : 32'h0));
         if (m_ev && bus.out_ready) void'(q.pop_front());
         if (bus.in_valid && bus.in_ready) begin
            m_e     = model(bus.Operation, bus.regA, bus.regB);
            m_e.due = cyc + m_e.lat;
            q.push_back(m_e);
         end
      end
   end

   task automatic wait_ready(input string name);
      int w;
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      check({name, "_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
   endtask

   task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic ei, input int el);
      int lat;
      wait_ready(name);
      bus.Operation = op;
      bus.regA      = a;
      bus.regB      = b;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.regA     = $urandom;
      bus.regB     = $urandom;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, lat, el);
      check({name, "_result"}, bus.ALUResult, er);
      check({name, "_zero"}, {31'h0, bus.zero}, {31'h0, ez});
      check({name, "_illegal"}, {31'h0, bus.illegal}, {31'h0, ei});
   endtask

   logic [3:0]  t_op [4] = '{4'h2, 4'h3, 4'h4, 4'h5};
   logic [31:0] t_a  [4] = '{32'd1, 32'hFF, 32'd1, 32'h8000_0000};
   logic [31:0] t_b  [4] = '{32'd2, 32'h0F, 32'd31, 32'h44};
   logic [31:0] t_r  [4] = '{32'd3, 32'hF0, 32'h8000_0000, 32'h0800_0000};

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish at t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t pin;
      bus.in_valid  = 1'b0;
      bus.regA      = 32'h0;
      bus.regB      = 32'h0;
      bus.Operation = 4'h0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("reset_result", bus.ALUResult, 32'h0);
      check("reset_zero", {31'h0, bus.zero}, 32'h0);
      check("reset_illegal", {31'h0, bus.illegal}, 32'h0);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);

      pin = model(4'h2, 32'hFFFF_FFFF, 32'd1);
      check("pin_add", pin.res, 32'h0);
      check("pin_add_zero", {31'h0, pin.z}, 32'h1);
      pin = model(4'h7, 32'h8000_0000, 32'h24);
      check("pin_sra", pin.res, 32'hF800_0000);
      pin = model(4'hB, 32'h1_0000, 32'h1_0000);
      check("pin_mulhu", pin.res, MD ? 32'h1 : 32'h0);
      pin = model(4'hD, 32'd100, 32'd7);
      check("pin_remu", pin.res, MD ? 32'd2 : 32'd0);

      @(posedge clk); #1;
      do_op("add_wrap", 4'h2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 1);
      do_op("sub", 4'h6, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      do_op("sra", 4'h7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b0, 1);
      do_op("slt", 4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
      do_op("sltu", 4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
      do_op("or", 4'h1, 32'hA0A0_0000, 32'h0000_0505, 32'hA0A0_0505, 1'b0, 1'b0, 1);
      do_op("sll", 4'h4, 32'd1, 32'h23, 32'd8, 1'b0, 1'b0, 1);

      // Back-to-back single-cycle ops with the consumer always ready.
      wait_ready("b2b");
      bus.Operation = t_op[0];
      bus.regA      = t_a[0];
      bus.regB      = t_b[0];
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("b2b_in_ready", {31'h0, bus.in_ready}, 32'h1);
         @(posedge clk); #1;
         check("b2b_out_valid", {31'h0, bus.out_valid}, 32'h1);
         check("b2b_result", bus.ALUResult, t_r[i]);
         if (i < 3) begin
            bus.Operation = t_op[i+1];
            bus.regA      = t_a[i+1];
            bus.regB      = t_b[i+1];
         end else begin
            bus.in_valid = 1'b0;
         end
      end

      // Back-pressure: result held, input side stalled.
      @(posedge clk); #1;
      wait_ready("bp");
      bus.out_ready = 1'b0;
      bus.Operation = 4'h2;
      bus.regA      = 32'd3;
      bus.regB      = 32'd4;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
         check("bp_result", bus.ALUResult, 32'd7);
         check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
         @(posedge clk); #1;
      end
      bus.Operation = 4'h0;
      bus.regA      = 32'hF0;
      bus.regB      = 32'h3C;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", {31'h0, bus.in_ready}, 32'h1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp_and_out_valid", {31'h0, bus.out_valid}, 32'h1);
      check("bp_and_result", bus.ALUResult, 32'h30);

      do_op("illegal_f", 4'hF, 32'd123, 32'd456, 32'h0, 1'b1, 1'b1, 1);
      do_op("mul", 4'hA, 32'h1_0000, 32'h1_0000, 32'h0, 1'b1, !MD, MD ? 33 : 1);
      do_op("mulhu", 4'hB, 32'h1_0000, 32'h1_0000, MD ? 32'd1 : 32'd0, !MD, !MD, MD ? 33 : 1);
      do_op("mul_small", 4'hA, 32'd7, 32'd6, MD ? 32'd42 : 32'd0, !MD, !MD, MD ? 33 : 1);
      do_op("divu", 4'hC, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, !MD, !MD, MD ? 33 : 1);
      do_op("remu", 4'hD, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, !MD, !MD, MD ? 33 : 1);
      do_op("divu_zero", 4'hC, 32'd12345, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0, !MD, !MD, MD ? 33 : 1);
      do_op("remu_zero", 4'hD, 32'd12345, 32'd0, MD ? 32'd12345 : 32'd0, !MD, !MD, MD ? 33 : 1);

      // Reset in the middle of a divide.
      wait_ready("mid_rst");
      bus.out_ready = 1'b0;
      bus.Operation = 4'hC;
      bus.regA      = 32'd1000;
      bus.regB      = 32'd3;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("mid_rst_result", bus.ALUResult, 32'h0);
      check("mid_rst_zero", {31'h0, bus.zero}, 32'h0);
      check("mid_rst_illegal", {31'h0, bus.illegal}, 32'h0);
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
      repeat (40) begin
         @(posedge clk); #1;
         check("post_rst_no_stale", {31'h0, bus.out_valid}, 32'h0);
      end
      do_op("post_rst_add", 4'h2, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);

      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
